aexm_xctl: RTL and testbench
============================

Name: aexm_xctl

Overview:
- Pipeline sequencer for the aexm execute stage. Generates the d_en/x_en strobes that advance operand latching and result/MSR commit in the execute unit.
- Inserts stall cycles for the registered barrel shifter, for data-cache load/store handshakes and for instruction-fetch bubbles.
- Takes interrupts at instruction boundaries.
- Sits between decode, the execute unit and the data-cache port.

Parameters:
- BSF, 1, barrel shifter present; 0 = ALU-class 5 ops take no extra cycle.
- MEMTO, 255, data-cache ack timeout in cycles (1..255).
- CW, 32, width of perf counter (optional feature only).

Ports:
- gclk  in  1  system clock, all state on rising edge
- grst_n  in  1  asynchronous active-low reset
- i_valid  in  1  decoded instruction valid this cycle
- x_mxalu  in  3  ALU result-select class of decoded instruction (5 = barrel shift)
- x_ldst  in  1  decoded instruction is load/store
- x_skip  in  1  instruction annulled (skip slot)
- irq  in  1  level interrupt request
- msr_ie  in  1  MSR interrupt-enable from execute unit
- dc_ack  in  1  data-cache access complete
- dc_req  out  1  data-cache access request
- d_en  out  1  operand-latch enable
- x_en  out  1  result/MSR commit enable
- int_take  out  1  one-cycle pulse, interrupt accepted
- bus_err  out  1  one-cycle pulse, dc_ack timeout
- perf_stall  out  CW  stall-cycle count (optional feature only)

Behaviour:
- Reset (grst_n low, async): state RST; d_en=0, x_en=0, dc_req=0, int_take=0, bus_err=0, timeout counter=0. First clock after release: RST->RUN, outputs still 0.
- All outputs are registered: a decision made in cycle N appears in cycle N+1.
- States: RST, RUN, SHF, MEM, INT.
- RUN: evaluate in priority order:
  - irq & msr_ie & !int_blk: ->INT. int_take=1, d_en=x_en=0. The instruction is not issued; it is replayed after INT.
  - !i_valid: stay RUN, d_en=x_en=0 (bubble).
  - x_skip: stay RUN, d_en=x_en=1. The annulled op flows through; no multicycle handling.
  - x_ldst: ->MEM, dc_req=1, d_en=x_en=0.
  - x_mxalu==5 & BSF: ->SHF, d_en=x_en=0. The shifter capture registers load while x_en is low.
  - Otherwise: stay RUN, d_en=x_en=1.
- SHF: exactly one cycle. d_en=x_en=1, ->RUN. BSF=0 makes SHF unreachable.
- MEM:
  - dc_req held 1 until ack; timeout counter increments each cycle.
  - dc_ack: dc_req=0, d_en=x_en=1, counter cleared, ->RUN.
  - counter==MEMTO without ack: dc_req=0, bus_err=1, d_en=x_en=1 (op retired with garbage data), ->RUN.
  - dc_ack and timeout in the same cycle: ack wins, no bus_err.
  - dc_ack seen in RUN, SHF or INT (spurious): ignored.
- INT: one cycle, d_en=x_en=0, int_take=0, int_blk=1, ->RUN.
- int_blk: set on entry to INT, cleared when the next instruction commits (d_en=x_en=1 in RUN). Guarantees forward progress: at least one instruction (the vector branch) executes between interrupts.
- irq arriving in SHF or MEM: not taken until back in RUN. Multicycle ops are never aborted.
- msr_ie is sampled only in RUN; changes during stalls have no effect until RUN.
- d_en and x_en are always equal in this revision. They are separate ports for future operand-forwarding stalls.
- Reset mid-MEM: dc_req drops immediately (async). A late dc_ack after reset is ignored.

Optional Feature:
- Macro AEXM_XCTL_PERF_EN.
- Defined: perf_stall port exists. It is a CW-bit counter, reset 0, incremented on every post-reset cycle where d_en=0, and wraps modulo 2^CW.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Shared package aexm_pkg holds:
  - state encoding (RST=0, RUN=1, SHF=2, MEM=3, INT=4; 3-bit);
  - ALU class constants (MX_ADD=0, MX_LOG=1, MX_SFT=2, MX_MOV=3, MX_BSF=5), to be reused by decode and the execute unit.
- One natural sub-module: aexm_xctl_tmo. Loadable 8-bit timeout counter with clear/enable and terminal-count output; reused later by the instruction-fetch controller.
- FSM and output registers stay in aexm_xctl.

Test Plan:
- Reset release, i_valid=1, x_mxalu=0 every cycle -> d_en=x_en=0 for 2 cycles after release, then 1 continuously.
- BSF=1, one op with x_mxalu=5 -> exactly one cycle of d_en=x_en=0, then 1. With BSF=0 -> no gap.
- x_ldst=1, dc_ack after 3 cycles -> dc_req high 4 cycles, d_en=x_en=1 in the ack cycle+1. Next instruction issues the cycle after that.
- x_ldst=1, MEMTO=4, no ack -> bus_err pulses once after 4 MEM cycles, dc_req drops, state returns to RUN.
- irq=1, msr_ie=1 held continuously -> int_take pulses once, then one instruction commits, then int_take pulses again. msr_ie=0 -> int_take never asserted.
- irq raised during MEM -> int_take only after the dc_ack commit. AEXM_XCTL_PERF_EN defined -> perf_stall equals the total d_en=0 cycle count at end of run.

Source files
------------

// File: rtl/aexm_pkg.sv
// aexm_pkg: shared aexm state encoding and ALU result-select class constants
package aexm_pkg;
  typedef enum logic [2:0] {
    RST = 3'd0,
    RUN = 3'd1,
    SHF = 3'd2,
    MEM = 3'd3,
    INT = 3'd4
  } xst_t;
  localparam logic [2:0] MX_ADD = 3'd0;
  localparam logic [2:0] MX_LOG = 3'd1;
  localparam logic [2:0] MX_SFT = 3'd2;
  localparam logic [2:0] MX_MOV = 3'd3;
  localparam logic [2:0] MX_BSF = 3'd5;
endpackage

// File: rtl/aexm_xctl_if.sv
// aexm_xctl_if: decode/execute/data-cache signals of the sequencer; slave = aexm_xctl, master = its environment; perf_stall only with AEXM_XCTL_PERF_EN
interface aexm_xctl_if #(parameter int CW = 32);
  logic       i_valid;
  logic [2:0] x_mxalu;
  logic       x_ldst;
  logic       x_skip;
  logic       irq;
  logic       msr_ie;
  logic       dc_ack;
  logic       dc_req;
  logic       d_en;
  logic       x_en;
  logic       int_take;
  logic       bus_err;
`ifdef AEXM_XCTL_PERF_EN
  logic [CW-1:0] perf_stall;
  modport slave (
    input  i_valid, x_mxalu, x_ldst, x_skip, irq, msr_ie, dc_ack,
    output dc_req, d_en, x_en, int_take, bus_err, perf_stall
  );
  modport master (
    output i_valid, x_mxalu, x_ldst, x_skip, irq, msr_ie, dc_ack,
    input  dc_req, d_en, x_en, int_take, bus_err, perf_stall
  );
`else
  if (CW > 0) begin : g_noperf
  end
  modport slave (
    input  i_valid, x_mxalu, x_ldst, x_skip, irq, msr_ie, dc_ack,
    output dc_req, d_en, x_en, int_take, bus_err
  );
  modport master (
    output i_valid, x_mxalu, x_ldst, x_skip, irq, msr_ie, dc_ack,
    input  dc_req, d_en, x_en, int_take, bus_err
  );
`endif
endinterface

// File: rtl/aexm_xctl_tmo.sv
// aexm_xctl_tmo: loadable 8-bit timeout counter (clr > ld > en) with terminal-count tc when count equals term
module aexm_xctl_tmo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  logic       en,
  input  logic [7:0] ld_val,
  input  logic [7:0] term,
  output logic       tc
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : ld ? ld_val : en ? cnt + 8'd1 : cnt;
  assign tc = cnt == term;
endmodule

// File: rtl/aexm_xctl.sv
// aexm_xctl: execute-stage sequencer (gclk, grst_n, bus: decode/irq/dc handshake in, d_en/x_en/dc_req/int_take/bus_err out; perf_stall with AEXM_XCTL_PERF_EN)
module aexm_xctl
  import aexm_pkg::*;
#(
  parameter int BSF   = 1,
  parameter int MEMTO = 255,
  parameter int CW    = 32
) (
  input logic       gclk,
  input logic       grst_n,
  aexm_xctl_if.slave bus
);
  xst_t st, nx;
  logic en_n, req_n, take_n, err_n, blk, tc;
  aexm_xctl_tmo u_tmo (
    .clk   (gclk),
    .rst_n (grst_n),
    .clr   (nx != MEM),
    .ld    (st != MEM && nx == MEM),
    .en    (st == MEM),
    .ld_val(8'd1),
    .term  (8'(MEMTO)),
    .tc    (tc)
  );
  always_comb begin
    nx     = st;
    en_n   = 1'b0;
    req_n  = 1'b0;
    take_n = 1'b0;
    err_n  = 1'b0;
    case (st)
      RST: nx = RUN;
      RUN:
        if (bus.irq && bus.msr_ie && !blk) begin
          nx     = INT;
          take_n = 1'b1;
        end else if (bus.i_valid) begin
          if (bus.x_skip) en_n = 1'b1;
          else if (bus.x_ldst) begin
            nx    = MEM;
            req_n = 1'b1;
          end else if (bus.x_mxalu == MX_BSF && BSF != 0) nx = SHF;
          else en_n = 1'b1;
        end
      SHF: begin
        nx   = RUN;
        en_n = 1'b1;
      end
      MEM:
        if (bus.dc_ack || tc) begin
          nx    = RUN;
          en_n  = 1'b1;
          err_n = !bus.dc_ack;
        end else req_n = 1'b1;
      INT: nx = RUN;
      default: nx = RST;
    endcase
  end
  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      st           <= RST;
      bus.d_en     <= 1'b0;
      bus.x_en     <= 1'b0;
      bus.dc_req   <= 1'b0;
      bus.int_take <= 1'b0;
      bus.bus_err  <= 1'b0;
      blk          <= 1'b0;
    end else begin
      st           <= nx;
      bus.d_en     <= en_n;
      bus.x_en     <= en_n;
      bus.dc_req   <= req_n;
      bus.int_take <= take_n;
      bus.bus_err  <= err_n;
      blk          <= nx == INT || (blk && !en_n);
    end
`ifdef AEXM_XCTL_PERF_EN
  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) bus.perf_stall <= '0;
    else bus.perf_stall <= bus.perf_stall + CW'(!bus.d_en);
`else
  if (CW > 0) begin : g_noperf
  end
`endif
endmodule

// File: tb/tb_aexm_xctl.sv
// tb_aexm_xctl: directed self-checking bench for aexm_xctl (instance a: BSF=1 MEMTO=4, instance b: BSF=0 MEMTO=255)
module tb_aexm_xctl;
  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  logic iv = 1'b1, ls = 1'b0, sk = 1'b0, irq = 1'b0, ie = 1'b0, ack = 1'b0;
  logic [2:0] mx = 3'd0;
  int checks = 0;
  int errors = 0;
  aexm_xctl_if #(.CW(32)) a ();
  aexm_xctl_if #(.CW(32)) b ();
  assign a.i_valid = iv;
  assign a.x_mxalu = mx;
  assign a.x_ldst  = ls;
  assign a.x_skip  = sk;
  assign a.irq     = irq;
  assign a.msr_ie  = ie;
  assign a.dc_ack  = ack;
  assign b.i_valid = iv;
  assign b.x_mxalu = mx;
  assign b.x_ldst  = ls;
  assign b.x_skip  = sk;
  assign b.irq     = irq;
  assign b.msr_ie  = ie;
  assign b.dc_ack  = ack;
  aexm_xctl #(.BSF(1), .MEMTO(4), .CW(32)) ua (.gclk(gclk), .grst_n(grst_n), .bus(a));
  aexm_xctl #(.BSF(0), .MEMTO(255), .CW(32)) ub (.gclk(gclk), .grst_n(grst_n), .bus(b));
  always #5 gclk = ~gclk;
`ifdef AEXM_XCTL_PERF_EN
  int stalls = 0;
  always @(posedge gclk or negedge grst_n)
    if (!grst_n) stalls = 0;
    else if (!a.d_en) stalls++;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge gclk);
    #1;
  endtask
  task automatic chk_en(input string tag, input logic exp);
    chk({tag, "_d"}, a.d_en, exp);
    chk({tag, "_x"}, a.x_en, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end
  initial begin
    step();
    step();
    chk_en("rst", 1'b0);
    chk("rst_req", a.dc_req, 1'b0);
    chk("rst_take", a.int_take, 1'b0);
    chk("rst_err", a.bus_err, 1'b0);
    chk("rst_b", b.d_en, 1'b0);
    grst_n = 1'b1;
    step();
    chk_en("rel1", 1'b0);
    step();
    chk_en("rel2", 1'b1);
    step();
    chk_en("rel3", 1'b1);
    chk("rel3_b", b.d_en, 1'b1);
    mx = 3'd5;
    step();
    chk_en("bsf_gap", 1'b0);
    chk("nobsf_gap", b.d_en, 1'b1);
    mx = 3'd0;
    step();
    chk_en("bsf_done", 1'b1);
    chk("nobsf_done", b.d_en, 1'b1);
    step();
    chk_en("bsf_next", 1'b1);
    ls = 1'b1;
    step();
    chk("ld_req0", a.dc_req, 1'b1);
    chk_en("ld_wait0", 1'b0);
    ls = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_req", a.dc_req, 1'b1);
      chk_en("ld_wait", 1'b0);
    end
    ack = 1'b1;
    step();
    chk("ld_ack_req", a.dc_req, 1'b0);
    chk_en("ld_ack", 1'b1);
    chk("ack_tmo_tie", a.bus_err, 1'b0);
    ack = 1'b0;
    step();
    chk_en("post_ld_issue", 1'b1);
    chk("post_ld_req", a.dc_req, 1'b0);
    ack = 1'b1;
    step();
    chk_en("spur_ack", 1'b1);
    chk("spur_req", a.dc_req, 1'b0);
    ack = 1'b0;
    sk = 1'b1;
    ls = 1'b1;
    step();
    chk_en("skip", 1'b1);
    chk("skip_req", a.dc_req, 1'b0);
    sk = 1'b0;
    step();
    chk("tmo_req0", a.dc_req, 1'b1);
    ls = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_req", a.dc_req, 1'b1);
      chk("tmo_noerr", a.bus_err, 1'b0);
    end
    step();
    chk("tmo_err", a.bus_err, 1'b1);
    chk("tmo_drop", a.dc_req, 1'b0);
    chk_en("tmo_retire", 1'b1);
    step();
    chk("tmo_err_pulse", a.bus_err, 1'b0);
    chk_en("tmo_run", 1'b1);
    irq = 1'b1;
    ie = 1'b1;
    step();
    chk("irq_take1", a.int_take, 1'b1);
    chk_en("irq_take1", 1'b0);
    step();
    chk("irq_int", a.int_take, 1'b0);
    chk_en("irq_int", 1'b0);
    step();
    chk("irq_commit", a.int_take, 1'b0);
    chk_en("irq_commit", 1'b1);
    step();
    chk("irq_take2", a.int_take, 1'b1);
    chk_en("irq_take2", 1'b0);
    ie = 1'b0;
    step();
    chk("irq_int2", a.int_take, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ie_off", a.int_take, 1'b0);
      chk_en("ie_off", 1'b1);
    end
    irq = 1'b0;
    ie = 1'b1;
    ls = 1'b1;
    step();
    chk("mirq_req", a.dc_req, 1'b1);
    ls = 1'b0;
    irq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mirq_hold", a.int_take, 1'b0);
      chk("mirq_req", a.dc_req, 1'b1);
    end
    ack = 1'b1;
    step();
    chk("mirq_ack_req", a.dc_req, 1'b0);
    chk_en("mirq_commit", 1'b1);
    chk("mirq_ack_take", a.int_take, 1'b0);
    ack = 1'b0;
    step();
    chk("mirq_take", a.int_take, 1'b1);
    chk_en("mirq_take", 1'b0);
    irq = 1'b0;
    step();
    chk("mirq_int", a.int_take, 1'b0);
    step();
    chk_en("mirq_vec", 1'b1);
    ls = 1'b1;
    step();
    chk("armem_req", a.dc_req, 1'b1);
    ls = 1'b0;
    step();
    #2;
    grst_n = 1'b0;
    #1;
    chk("async_req", a.dc_req, 1'b0);
    chk_en("async", 1'b0);
    ack = 1'b1;
    step();
    grst_n = 1'b1;
    step();
    chk("late_ack_req1", a.dc_req, 1'b0);
    chk_en("late_ack1", 1'b0);
    step();
    chk("late_ack_req2", a.dc_req, 1'b0);
    chk_en("late_ack2", 1'b1);
    ack = 1'b0;
    step();
`ifdef AEXM_XCTL_PERF_EN
    chk("perf", a.perf_stall, stalls);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
